// File: rtl/mat_iscan_if.sv
// Sample stream bundle for mat_iscan: zigzag samples in, raster samples out.
// MAT_ISCAN_SOF_EN adds the sof_out start-of-block marker.
interface mat_iscan_if #(
    parameter int DW = 10
);
    logic          vld_in;
    logic [DW-1:0] din;
    logic          vld_out;
    logic [DW-1:0] dout;
`ifdef MAT_ISCAN_SOF_EN
    logic          sof_out;

    modport master (output vld_in, din, input vld_out, dout, sof_out);
    modport slave  (input vld_in, din, output vld_out, dout, sof_out);
`else
    modport master (output vld_in, din, input vld_out, dout);
    modport slave  (input vld_in, din, output vld_out, dout);
`endif
endinterface

// File: rtl/mat_iscan.sv
// Inverse zigzag scan: ping-pong buffers a BLK_N x BLK_N block and emits it in raster order.
// Optional MAT_ISCAN_SOF_EN drives sof_out on raster sample 0 of every block.
module mat_iscan #(
    parameter int DW    = 10,
    parameter int BLK_N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mat_iscan_if.slave  bus
);
    localparam int NS = BLK_N * BLK_N;
    localparam int AW = $clog2(NS);

    // Walks the zigzag path once, recording the raster address reached at each step k.
    function automatic logic [NS*AW-1:0] build_zz();
        logic [NS*AW-1:0] tab;
        int r;
        int c;
        tab = '0;
        r   = 0;
        c   = 0;
        for (int k = 0; k < NS; k++) begin
            tab[k*AW +: AW] = AW'(r * BLK_N + c);
            if (((r + c) % 2) == 0) begin
                if (c == BLK_N - 1)  r = r + 1;
                else if (r == 0)     c = c + 1;
                else begin r = r - 1; c = c + 1; end
            end else begin
                if (r == BLK_N - 1)  c = c + 1;
                else if (c == 0)     r = r + 1;
                else begin r = r + 1; c = c - 1; end
            end
        end
        return tab;
    endfunction

    localparam logic [NS*AW-1:0] ZZ_TAB = build_zz();

    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    logic [DW-1:0] mem [2*NS];
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic          wbank;
    logic          rbank;
    logic [1:0]    full;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    rd_state_t     rd_state;
    logic [AW-1:0] waddr;
    logic          wr_last;
    logic          rd_last;
    logic          idle_bank;
    logic          other_ready;

    assign waddr   = ZZ_TAB[wcnt*AW +: AW];
    assign wr_last = bus.vld_in && (wcnt == AW'(NS - 1));
    assign rd_last = (rd_state == RD_RUN) && (rcnt == AW'(NS - 1));
    // The most recently filled bank is the one wbank just toggled away from.
    assign idle_bank   = full[~wbank] ? ~wbank : wbank;
    assign other_ready = full[~rbank] || (wr_last && (wbank != rbank));

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_last) full_set[wbank] = 1'b1;
        if (rd_last) full_clr[rbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (bus.vld_in) mem[{wbank, waddr}] <= bus.din;
    end

    // Sample 0 is launched straight from idle so the first raster output lands one cycle after the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            wbank       <= 1'b0;
            full        <= '0;
            rd_state    <= RD_IDLE;
            rbank       <= 1'b0;
            rcnt        <= '0;
            bus.vld_out <= 1'b0;
            bus.dout    <= '0;
`ifdef MAT_ISCAN_SOF_EN
            bus.sof_out <= 1'b0;
`endif
        end else begin
            if (bus.vld_in) begin
                if (wr_last) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt  <= wcnt + 1'b1;
                end
            end
            full <= (full & ~full_clr) | full_set;

            case (rd_state)
                RD_IDLE: begin
                    if (|full) begin
                        rbank       <= idle_bank;
                        rcnt        <= AW'(1);
                        bus.dout    <= mem[{idle_bank, AW'(0)}];
                        bus.vld_out <= 1'b1;
`ifdef MAT_ISCAN_SOF_EN
                        bus.sof_out <= 1'b1;
`endif
                        rd_state    <= RD_RUN;
                    end else begin
                        bus.vld_out <= 1'b0;
`ifdef MAT_ISCAN_SOF_EN
                        bus.sof_out <= 1'b0;
`endif
                    end
                end
                RD_RUN: begin
                    bus.dout    <= mem[{rbank, rcnt}];
                    bus.vld_out <= 1'b1;
`ifdef MAT_ISCAN_SOF_EN
                    bus.sof_out <= (rcnt == '0);
`endif
                    rcnt        <= rcnt + 1'b1;
                    if (rd_last) begin
                        rcnt <= '0;
                        if (other_ready) rbank    <= ~rbank;
                        else             rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_iscan.sv
// Directed bench for mat_iscan (BLK_N=8): raster order, gapless streaming, gaps, mid-stream reset.
// With MAT_ISCAN_SOF_EN defined the sof_out marker is checked as well.
module tb_mat_iscan;
    localparam int DW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mat_iscan_if #(.DW(DW)) bus ();

    mat_iscan #(.DW(DW), .BLK_N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // JPEG zigzag index found at each raster position, row by row.
    int raster_zz [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };
    int zz_raster [64];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lw;
    logic [31:0] out_val [$];
    logic [31:0] out_cyc [$];
    logic        out_sof [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Every valid output is logged with the index of the edge that produced it.
    always @(negedge clk) begin
        if (bus.vld_out === 1'b1) begin
            out_val.push_back(32'(bus.dout));
            out_cyc.push_back(32'(cyc));
`ifdef MAT_ISCAN_SOF_EN
            out_sof.push_back(bus.sof_out);
`else
            out_sof.push_back(1'b0);
`endif
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input int d);
        bus.vld_in = v;
        bus.din    = DW'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 0);
    endtask

    task automatic clear_capture();
        out_val.delete();
        out_cyc.delete();
        out_sof.delete();
    endtask

    function automatic logic [31:0] got_val(input int i);
        return (i < out_val.size()) ? out_val[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] got_cyc(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_block(input string tag, input int first, input int offset);
        for (int i = 0; i < 64; i++)
            check_output(tag, got_val(first + i), 32'(offset + raster_zz[i]));
    endtask

    task automatic check_timing(input string tag, input int n);
        check_output({tag, "_count"}, 32'(out_val.size()), 32'(n));
        check_output({tag, "_first_cyc"}, got_cyc(0), 32'(lw + 1));
        check_output({tag, "_last_cyc"}, got_cyc(n - 1), 32'(lw + n));
    endtask

    initial begin
        int k;
        for (int a = 0; a < 64; a++) zz_raster[raster_zz[a]] = a;
        bus.vld_in = 1'b0;
        bus.din    = '0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_vld_out", 32'(bus.vld_out), 32'd0);
        check_output("reset_dout", 32'(bus.dout), 32'd0);
`ifdef MAT_ISCAN_SOF_EN
        check_output("reset_sof_out", 32'(bus.sof_out), 32'd0);
`endif
        rst_n = 1'b1;
        idle(2);

        $display("[TB] single block 0..63");
        clear_capture();
        for (int i = 0; i < 64; i++) apply_stimulus(1'b1, i);
        lw = cyc;
        idle(72);
        check_timing("blk1", 64);
        check_block("blk1_data", 0, 0);
        check_output("blk1_row0_col2", got_val(2), 32'd5);
        check_output("blk1_last", got_val(63), 32'd63);

        $display("[TB] gapless 128-sample stream");
        clear_capture();
        for (int i = 0; i < 128; i++) begin
            apply_stimulus(1'b1, i);
            if (i == 63) lw = cyc;
        end
        idle(72);
        check_timing("stream", 128);
        check_block("stream_blk0", 0, 0);
        check_block("stream_blk1", 64, 64);
        check_output("stream_blk1_first", got_val(64), 32'd64);
`ifdef MAT_ISCAN_SOF_EN
        for (int i = 0; i < 128; i++)
            check_output("stream_sof", (i < out_sof.size()) ? 32'(out_sof[i]) : 32'hFFFF_FFFF,
                         32'((i % 64) == 0));
`endif

        $display("[TB] block with a gap every third cycle");
        clear_capture();
        k = 0;
        for (int s = 0; k < 64; s++) begin
            if ((s % 3) == 2) apply_stimulus(1'b0, 999);
            else begin
                apply_stimulus(1'b1, k);
                k++;
            end
        end
        lw = cyc;
        idle(72);
        check_timing("gaps", 64);
        check_block("gaps_data", 0, 0);

        $display("[TB] partial block then mid-stream reset");
        clear_capture();
        for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 500 + i);
        idle(5);
        check_output("partial_no_output", 32'(out_val.size()), 32'd0);
        apply_stimulus(1'b1, 530);
        rst_n = 1'b0;
        #1;
        check_output("rst_vld_out", 32'(bus.vld_out), 32'd0);
        bus.vld_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 100 + i);
        lw = cyc;
        idle(72);
        check_timing("after_rst", 64);
        check_output("after_rst_0", got_val(0), 32'd100);
        check_output("after_rst_1", got_val(1), 32'd101);
        check_output("after_rst_2", got_val(2), 32'd105);
        check_block("after_rst_data", 0, 100);

        $display("[TB] zigzag-ordered raster indices come back in order");
        clear_capture();
        for (int i = 0; i < 64; i++) apply_stimulus(1'b1, zz_raster[i]);
        lw = cyc;
        idle(72);
        check_timing("chain", 64);
        for (int i = 0; i < 64; i++) check_output("chain_data", got_val(i), 32'(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
